ram_wishbone_bsel: RTL
======================

// Module: ram_wishbone_bsel
// PURPOSE
//  Parametrised Wishbone B4 classic slave RAM for the SoC data bus. Successor to the
//  byte-array data RAM: adds byte selects, a registered read, an ACK_O handshake and a
//  sequenced memory clear after reset. Sits behind the bus interconnect as data memory.
// PARAMETERS
//  DATA_WIDTH  32   bus data width in bits; multiple of 8 (8/16/32/64)
//  DEPTH       256  number of DATA_WIDTH-bit words; power of 2, >=2
//  ADR_WIDTH   32   ADR_I width in bits (byte address)
//  BASE_ADDR   0    byte address of word 0; aligned to DEPTH*DATA_WIDTH/8
// PORTS
//  CLK_I  in   1             clock; all logic on rising edge
//  RST_I  in   1             reset, synchronous, active-high
//  CYC_I  in   1             bus cycle valid
//  STB_I  in   1             strobe; a request is CYC_I & STB_I
//  WE_I   in   1             1 = write, 0 = read
//  SEL_I  in   DATA_WIDTH/8  byte lane enables; bit n -> DAT_I[8n+7:8n]
//  ADR_I  in   ADR_WIDTH     byte address
//  DAT_I  in   DATA_WIDTH    write data
//  DAT_O  out  DATA_WIDTH    registered read data, valid while ACK_O=1
//  ACK_O  out  1             single-cycle transfer acknowledge
//  ERR_O  out  1             error acknowledge (constant 0 unless RAM_WB_ERR_EN)
// BEHAVIOUR
//  - Word index = (ADR_I - BASE_ADDR) >> log2(DATA_WIDTH/8), truncated to log2(DEPTH)
//    bits (wraps modulo DEPTH); byte-offset bits of ADR_I ignored.
//  - FSM states: CLEAR, IDLE, RESP.
//  - RST_I=1: state<=CLEAR, clear counter<=0, ACK_O<=0, ERR_O<=0, DAT_O<=0. Overrides any
//    cycle in progress; a pending ACK is dropped, the clear restarts from word 0.
//  - CLEAR: writes word[cnt]<=0 each cycle, cnt++; after word DEPTH-1 -> IDLE. Clear takes
//    exactly DEPTH cycles after RST_I falls. Requests are ignored (no ACK) during CLEAR;
//    the master simply waits.
//  - IDLE: on CYC_I&STB_I -> RESP. Write: for each n with SEL_I[n]=1, byte n of word <=
//    DAT_I byte n; other bytes unchanged; DAT_O holds its previous value. Read: DAT_O <=
//    full word (SEL_I does not mask reads). ACK_O<=1 at the same edge.
//  - Latency: ACK_O asserts on the edge after the request is sampled (one wait state).
//  - RESP: ACK_O<=0, -> IDLE; requests in RESP are not sampled. Max throughput one
//    transfer per 2 clocks; a master holding STB_I after ACK starts a new transfer.
//  - SEL_I=0 write: acknowledged, memory unchanged.
//  - CYC_I dropped in RESP: ACK_O still pulses once; write already committed.
//  - Read after write to same word: returns merged data (write commits at request edge).
//  - ACK_O and ERR_O are never both 1.
// CONFIGURATION
//  RAM_WB_ERR_EN defined: requests whose address is outside
//    [BASE_ADDR, BASE_ADDR+DEPTH*DATA_WIDTH/8) or not aligned to DATA_WIDTH/8 bytes get
//    ERR_O=1 (same timing as ACK_O) instead of ACK_O; no memory write, DAT_O unchanged.
//  RAM_WB_ERR_EN undefined: ERR_O tied 0; such addresses wrap/truncate as above and ACK.
// TESTING (defaults DATA_WIDTH=32, DEPTH=256, BASE_ADDR=0 unless stated)
//  1 Reset then clear: preload word 5=32'hDEADBEEF, RST_I 1 cycle -> no ACK for 256 cycles
//    despite STB; then read 0x14 -> ACK 2nd edge, DAT_O=32'h00000000.
//  2 Byte write: write 0x10 DAT_I=32'h11223344 SEL=4'hF, then DAT_I=32'hAABBCCDD
//    SEL=4'b0101 -> read 0x10 returns 32'h11BB33DD.
//  3 Handshake: hold CYC/STB high for 3 reads of 0x0,0x4,0x8 -> ACK_O pattern 0,1,0,1,0,1,
//    DAT_O correct on each ACK cycle; ACK_O never high 2 consecutive cycles.
//  4 Reset mid-cycle: assert RST_I the cycle ACK_O would rise -> ACK_O stays 0, clear
//    restarts, read after 256 cycles returns 0.
//  5 Wrap/ERR: write 0x400 with 32'hCAFEF00D -> without RAM_WB_ERR_EN ACK and word 0 ==
//    32'hCAFEF00D; with RAM_WB_ERR_EN ERR_O=1, ACK_O=0, word 0 unchanged; likewise 0x2.
//  6 Width sweep: DATA_WIDTH=64, DEPTH=16: write 0x8 SEL=8'h0F data 64'h0102030405060708
//    -> read 0x8 returns 64'h0000000005060708.

Source files
------------

// File: rtl/ram_wishbone_bsel.sv
// rtl/ram_wishbone_bsel.sv - Wishbone B4 classic slave RAM with byte selects and post-reset clear
//
// Purpose: data memory behind the SoC bus interconnect. Registered read data,
// one wait state per transfer, and a word-by-word memory clear after reset.
// Optional feature macro: RAM_WB_ERR_EN (error acknowledge for out-of-range or
// misaligned addresses; when undefined ERR_O is tied low and addresses wrap).
//
// Ports:
//   CLK_I  clock, rising edge
//   RST_I  synchronous active-high reset
//   CYC_I  bus cycle valid
//   STB_I  strobe; request = CYC_I & STB_I
//   WE_I   1 = write, 0 = read
//   SEL_I  byte lane enables (bit n -> DAT_I[8n+7:8n])
//   ADR_I  byte address
//   DAT_I  write data
//   DAT_O  registered read data, valid while ACK_O = 1
//   ACK_O  single-cycle transfer acknowledge
//   ERR_O  error acknowledge

module ram_wishbone_bsel #(
  parameter int                   DATA_WIDTH = 32,
  parameter int                   DEPTH      = 256,
  parameter int                   ADR_WIDTH  = 32,
  parameter logic [ADR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                    CLK_I,
  input  logic                    RST_I,
  input  logic                    CYC_I,
  input  logic                    STB_I,
  input  logic                    WE_I,
  input  logic [DATA_WIDTH/8-1:0] SEL_I,
  input  logic [ADR_WIDTH-1:0]    ADR_I,
  input  logic [DATA_WIDTH-1:0]   DAT_I,
  output logic [DATA_WIDTH-1:0]   DAT_O,
  output logic                    ACK_O,
  output logic                    ERR_O
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int BW = $clog2(NB);
  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           cnt_q, cnt_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   dat_q, dat_d;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic [ADR_WIDTH-1:0]    offset;
  logic [IW-1:0]           req_idx;
  logic                    req;
  logic                    addr_bad;

  logic                    wr_en;
  logic [IW-1:0]           wr_idx;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [NB-1:0]           wr_be;

  // Byte offset from the base; the word index drops the in-word byte bits and
  // keeps only log2(DEPTH) bits, so out-of-range addresses wrap modulo DEPTH.
  assign offset  = ADR_I - BASE_ADDR;
  assign req_idx = offset[BW +: IW];
  assign req     = CYC_I & STB_I;

  // Only a slice of the offset feeds the index in the wrapping build.
  logic unused_offset;
  assign unused_offset = ^offset;

`ifdef RAM_WB_ERR_EN
  localparam logic [ADR_WIDTH:0]   SPAN       = (ADR_WIDTH+1)'(DEPTH * NB);
  localparam logic [ADR_WIDTH-1:0] ALIGN_MASK = ADR_WIDTH'(NB - 1);
  // An address below the base wraps to a huge offset, so one compare covers both ends.
  assign addr_bad = ({1'b0, offset} >= SPAN) || ((offset & ALIGN_MASK) != '0);
`else
  assign addr_bad = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    dat_d   = dat_q;
    wr_en   = 1'b0;
    wr_idx  = req_idx;
    wr_data = DAT_I;
    wr_be   = SEL_I;

    case (state_q)
      ST_CLEAR: begin
        wr_en   = 1'b1;
        wr_idx  = cnt_q;
        wr_data = '0;
        wr_be   = '1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == IW'(DEPTH - 1)) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (req) begin
          state_d = ST_RESP;
          if (addr_bad) begin
            err_d = 1'b1;
          end else begin
            ack_d = 1'b1;
            if (WE_I) begin
              wr_en = 1'b1;
            end else begin
              dat_d = mem_q[req_idx];
            end
          end
        end
      end
      ST_RESP: begin
        // Requests are not sampled here; this caps throughput at one per two clocks.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
    end
  end

  // Storage has no reset of its own; the CLEAR sequence zeroes it.
  always_ff @(posedge CLK_I) begin
    if (wr_en && !RST_I) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be[b]) begin
          mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  assign DAT_O = dat_q;
  assign ACK_O = ack_q;
  assign ERR_O = err_q;

endmodule
